// File: rtl/audio_dac_serializer_if.sv
// Sample-pair write port of the DAC serializer: push handshake plus FIFO status.
// The producer uses the master modport, the serializer the slave modport.
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
);
  logic                          write;
  logic [DATA_WIDTH-1:0]         writedata_left;
  logic [DATA_WIDTH-1:0]         writedata_right;
  logic                          write_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          underflow;

  modport master (
    output write, writedata_left, writedata_right,
    input  write_ready, fifo_level, underflow
  );

  modport slave (
    input  write, writedata_left, writedata_right,
    output write_ready, fifo_level, underflow
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer: buffers stereo pairs in a small FIFO and shifts them out
// MSB-first on AUD_DACDAT, timed by CODEC-mastered BCLK/LRCK sampled in CLOCK_50.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  audio_dac_serializer_if.slave  wr_bus,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_DACLRCK,
  output logic                   AUD_DACDAT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  // bit 0 = BCLK, bit 1 = LRCK
  logic [1:0] sync1_reg, sync2_reg, hist_reg;
  logic       bclk_fall, lrck_fall, lrck_rise;

  logic [2*DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [2*DATA_WIDTH-1:0] fifo_head;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]        level_reg;
  logic                    fifo_empty, write_ready_int, push, pop, frame_start;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   shift_reg, hold_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    dacdat_reg, underflow_reg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      hist_reg  <= '0;
    end else begin
      sync1_reg <= {AUD_DACLRCK, AUD_BCLK};
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  assign bclk_fall = hist_reg[0] & ~sync2_reg[0];
  assign lrck_fall = hist_reg[1] & ~sync2_reg[1];
  assign lrck_rise = ~hist_reg[1] & sync2_reg[1];

  assign fifo_empty      = (level_reg == '0);
  assign write_ready_int = (level_reg != FULL_LEVEL);
  assign push            = wr_bus.write & write_ready_int;
  // A falling LRCK only starts a frame from IDLE or RIGHT; LEFT always leaves on a rise.
  assign frame_start     = lrck_fall & (state_reg != LEFT);
  assign pop             = frame_start & ~fifo_empty;
  assign fifo_head       = fifo_mem[rd_ptr_reg];

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {wr_bus.writedata_left, wr_bus.writedata_right};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      state_reg     <= IDLE;
      shift_reg     <= '0;
      hold_reg      <= '0;
      bit_cnt_reg   <= '0;
      dacdat_reg    <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      underflow_reg <= 1'b0;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase

      // LRCK edges take priority over a coincident BCLK fall: that BCLK is the delay slot.
      if (frame_start) begin
        state_reg   <= LEFT;
        bit_cnt_reg <= '0;
        dacdat_reg  <= 1'b0;
        if (fifo_empty) begin
          shift_reg     <= '0;
          hold_reg      <= '0;
          underflow_reg <= 1'b1;
        end else begin
          shift_reg <= fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
          hold_reg  <= fifo_head[DATA_WIDTH-1:0];
        end
      end else if (state_reg == LEFT && lrck_rise) begin
        state_reg   <= RIGHT;
        shift_reg   <= hold_reg;
        bit_cnt_reg <= '0;
        dacdat_reg  <= 1'b0;
      end else if (state_reg != IDLE && bclk_fall) begin
        if (bit_cnt_reg != LAST_BIT) begin
          dacdat_reg  <= shift_reg[DATA_WIDTH-1];
          shift_reg   <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end else begin
          dacdat_reg <= 1'b0;
        end
      end
    end
  end

  assign wr_bus.write_ready = write_ready_int;
  assign wr_bus.fifo_level  = level_reg;
  assign wr_bus.underflow   = underflow_reg;
  assign AUD_DACDAT         = dacdat_reg;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Scoreboard bench for audio_dac_serializer: pushes expected pairs into a queue and
// a frame monitor compares each serialized half-frame and underflow count against it.
module tb_audio_dac_serializer;

  logic clk;
  logic reset_n;
  logic aud_bclk;
  logic aud_lrck;
  logic aud_dacdat;

  audio_dac_serializer_if #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dac_if();

  audio_dac_serializer #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .wr_bus      (dac_if),
    .AUD_BCLK    (aud_bclk),
    .AUD_DACLRCK (aud_lrck),
    .AUD_DACDAT  (aud_dacdat)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int uf_total = 0;
  int rst_events = 0;
  logic [47:0] exp_q [$];

  logic [47:0] full_pairs [4] = '{48'h000001_FFFFFE, 48'h7FFFFF_800000,
                                  48'hC3C3C3_3C3C3C, 48'h0F0F0F_F0F0F0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dac_if.underflow === 1'b1) uf_total++;
  always @(negedge reset_n) rst_events++;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ser(input logic [23:0] w);
    return {1'b0, w, 7'b0};
  endfunction

  // CODEC clocks: BCLK period 16 cycles, 32 BCLKs per half-frame, LRCK toggles with a BCLK fall
  initial begin
    aud_bclk = 1'b1;
    aud_lrck = 1'b1;
    forever begin
      for (int b = 0; b < 32; b++) begin
        repeat (8) @(negedge clk);
        aud_bclk = 1'b0;
        if (b == 0) aud_lrck = ~aud_lrck;
        repeat (8) @(negedge clk);
        aud_bclk = 1'b1;
      end
    end
  end

  // Frame monitor: one expected pair (or zeros with an underflow) per LRCK falling edge
  initial begin
    int          frame = 0;
    logic [47:0] exp_pair;
    int          exp_uf, uf_base, rst_base;
    bit          armed;
    logic [31:0] got_l, got_r;
    forever begin
      @(negedge aud_lrck);
      frame++;
      armed    = (reset_n === 1'b1);
      rst_base = rst_events;
      uf_base  = uf_total;
      if (exp_q.size() > 0) begin
        exp_pair = exp_q.pop_front();
        exp_uf   = 0;
      end else begin
        exp_pair = '0;
        exp_uf   = 1;
      end
      got_l = '0;
      for (int i = 0; i < 32; i++) begin
        @(posedge aud_bclk);
        got_l = {got_l[30:0], aud_dacdat};
      end
      if (armed && rst_events == rst_base) begin
        $display("frame %0d left  got %h exp %h", frame, got_l, ser(exp_pair[47:24]));
        check_eq("left_word", {32'h0, got_l}, {32'h0, ser(exp_pair[47:24])});
      end
      got_r = '0;
      for (int i = 0; i < 32; i++) begin
        @(posedge aud_bclk);
        got_r = {got_r[30:0], aud_dacdat};
      end
      if (armed && rst_events == rst_base) begin
        $display("frame %0d right got %h exp %h underflow pulses %0d exp %0d",
                 frame, got_r, ser(exp_pair[23:0]), uf_total - uf_base, exp_uf);
        check_eq("right_word", {32'h0, got_r}, {32'h0, ser(exp_pair[23:0])});
        check_eq("underflow_pulses", 64'(uf_total - uf_base), 64'(exp_uf));
      end
    end
  end

  task automatic push(input logic [23:0] l, input logic [23:0] r, output bit accepted);
    dac_if.write           = 1'b1;
    dac_if.writedata_left  = l;
    dac_if.writedata_right = r;
    accepted               = dac_if.write_ready;
    @(negedge clk);
    dac_if.write = 1'b0;
    if (accepted) exp_q.push_back({l, r});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int bad_dat = 0, bad_rdy = 0, bad_lvl = 0, bad_uf = 0, nz = 0;
    bit seen_fall;
    logic prev_lrck;

    reset_n                = 1'b0;
    dac_if.write           = 1'b1;
    dac_if.writedata_left  = 24'h5A5A5A;
    dac_if.writedata_right = 24'hA5A5A5;

    // Reset held with write asserted and CODEC clocks running
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (aud_dacdat !== 1'b0) bad_dat++;
      if (dac_if.write_ready !== 1'b1) bad_rdy++;
      if (dac_if.fifo_level !== 3'd0) bad_lvl++;
      if (dac_if.underflow !== 1'b0) bad_uf++;
      dac_if.writedata_left = 24'($urandom);
    end
    check_eq("reset_dacdat_errs", 64'(bad_dat), 64'd0);
    check_eq("reset_ready_errs", 64'(bad_rdy), 64'd0);
    check_eq("reset_level_errs", 64'(bad_lvl), 64'd0);
    check_eq("reset_underflow_errs", 64'(bad_uf), 64'd0);
    dac_if.write = 1'b0;
    reset_n      = 1'b1;

    // Single pair, pushed mid-frame of F1 (F1 itself underflows)
    @(posedge aud_lrck);
    repeat (20) @(negedge clk);
    push(24'hABCDEF, 24'h123456, acc);
    check_eq("push_latency_level", 64'(dac_if.fifo_level), 64'd1);

    // Full FIFO during F2's right half
    @(posedge aud_lrck);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push(full_pairs[k][47:24], full_pairs[k][23:0], acc);
      check_eq("fill_level", 64'(dac_if.fifo_level), 64'(k + 1));
    end
    check_eq("full_ready", 64'(dac_if.write_ready), 64'd0);
    push(24'hDEAD00, 24'hBEEF00, acc);
    check_eq("fifth_write_accepted", 64'(acc), 64'd0);
    check_eq("full_level_after_fifth", 64'(dac_if.fifo_level), 64'd4);

    // Pop latency at F3 start
    @(negedge aud_lrck);
    repeat (2) @(negedge clk);
    check_eq("pre_pop_level", 64'(dac_if.fifo_level), 64'd4);
    check_eq("pre_pop_ready", 64'(dac_if.write_ready), 64'd0);
    @(negedge clk);
    check_eq("post_pop_level", 64'(dac_if.fifo_level), 64'd3);
    check_eq("post_pop_ready", 64'(dac_if.write_ready), 64'd1);

    // F3..F6 drain, F7/F8 underflow, push mid-F8 for F9
    repeat (6) @(posedge aud_lrck);
    repeat (20) @(negedge clk);
    push(24'h135790, 24'h2468AC, acc);

    // Two pairs in F9 right half, third pushed in the F10 pop cycle
    @(posedge aud_lrck);
    repeat (20) @(negedge clk);
    push(24'hA5A5A5, 24'h5A5A5A, acc);
    push(24'h112233, 24'h445566, acc);
    @(negedge aud_lrck);
    repeat (2) @(negedge clk);
    check_eq("simul_level_before", 64'(dac_if.fifo_level), 64'd2);
    dac_if.write           = 1'b1;
    dac_if.writedata_left  = 24'h778899;
    dac_if.writedata_right = 24'hAABBCC;
    acc                    = dac_if.write_ready;
    @(negedge clk);
    dac_if.write = 1'b0;
    if (acc) exp_q.push_back(48'h778899_AABBCC);
    check_eq("simul_level_after", 64'(dac_if.fifo_level), 64'd2);

    // Reset mid-word: pair for F13 pushed in F12 right half
    repeat (3) @(posedge aud_lrck);
    repeat (20) @(negedge clk);
    push(24'hFFF000, 24'h000FFF, acc);
    @(negedge aud_lrck);
    repeat (168) @(negedge clk);
    check_eq("pre_reset_dacdat", 64'(aud_dacdat), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset_dacdat", 64'(aud_dacdat), 64'd0);
    check_eq("midreset_level", 64'(dac_if.fifo_level), 64'd0);
    check_eq("midreset_ready", 64'(dac_if.write_ready), 64'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    push(24'h800001, 24'h7FFFFE, acc);

    seen_fall = 1'b0;
    prev_lrck = aud_lrck;
    for (int i = 0; i < 3000 && !seen_fall; i++) begin
      @(negedge clk);
      if (prev_lrck === 1'b1 && aud_lrck === 1'b0) seen_fall = 1'b1;
      else if (aud_dacdat !== 1'b0) nz++;
      prev_lrck = aud_lrck;
    end
    check_eq("idle_after_reset_nonzero", 64'(nz), 64'd0);
    check_eq("frame_after_reset_seen", 64'(seen_fall), 64'd1);

    // Let the monitor finish the post-reset frame
    @(posedge aud_lrck);
    @(negedge aud_lrck);
    repeat (2) @(negedge clk);
    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Transmit-side serializer for the audio CODEC's DAC path. It accepts stereo sample pairs from the filter datapath through the same `write` / `write_ready` / `writedata_left` / `writedata_right` handshake the CODEC interface presents. It buffers the pairs in a small FIFO and shifts them out MSB-first on `AUD_DACDAT` in I2S format. `AUD_BCLK` and `AUD_DACLRCK` are driven by the CODEC (CODEC is master); this block samples them in the `CLOCK_50` domain.

## Interface
Parameters:
- `DATA_WIDTH`, 24: bits per channel sample.
- `FIFO_DEPTH`, 4: stereo pairs buffered; power of two, at least 2.

Ports:
- `CLOCK_50`  in  1  system clock; the only clock in the block.
- `reset_n`  in  1  asynchronous active-low reset.
- `write`  in  1  push request; accepted only when `write_ready` is 1.
- `writedata_left`  in  DATA_WIDTH  left sample, two's complement.
- `writedata_right`  in  DATA_WIDTH  right sample, two's complement.
- `write_ready`  out  1  FIFO not full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of pairs currently stored.
- `underflow`  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- `AUD_BCLK`  in  1  CODEC bit clock, asynchronous to `CLOCK_50`.
- `AUD_DACLRCK`  in  1  CODEC frame clock: low = left word, high = right word.
- `AUD_DACDAT`  out  1  serial data to the CODEC.

## Operation
- **Synchronisers.** `AUD_BCLK` and `AUD_DACLRCK` each pass through a 2-flop synchroniser, followed by a history flop.
  - Edge detection uses the history flop against the second synchroniser stage.
  - All three flops reset to 0, so no edge is detected spuriously out of reset.
- **FIFO.** Circular buffer of `FIFO_DEPTH` entries, each `{left, right}`.
  - Push when `write && write_ready`.
  - A push while full cannot occur, because `write` is ignored when `write_ready` is 0.
  - Pop only at a left-frame start.
  - Simultaneous push and pop: both take effect, and `fifo_level` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **State machine:** `IDLE`, `LEFT`, `RIGHT`.
  - `IDLE`: `AUD_DACDAT` = 0. On an LRCK falling edge, go to `LEFT` and do the frame-start load.
  - Frame-start load:
    - If FIFO is non-empty: pop, left sample into the shift register, right sample into the holding register.
    - If FIFO is empty: load 0 into both registers and pulse `underflow`.
  - `LEFT`: on an LRCK rising edge, load the holding register into the shift register, clear the bit counter, and go to `RIGHT`.
  - `RIGHT`: on an LRCK falling edge, do the frame-start load and go to `LEFT`.
  - LRCK edges are never missed: there is no skipping from `LEFT` to `LEFT`.
- **I2S bit timing.**
  - On each LRCK edge, the bit counter clears and `AUD_DACDAT` is driven to 0. This covers the I2S one-BCLK delay slot.
  - Each later BCLK falling edge, while counter < `DATA_WIDTH`: drive the shift-register MSB onto `AUD_DACDAT`, shift left, and increment the counter.
  - Once counter = `DATA_WIDTH`: `AUD_DACDAT` = 0 until the next LRCK edge.
  - If an LRCK edge and a BCLK falling edge are detected in the same cycle, the LRCK edge wins. That BCLK edge is the delay slot and shifts nothing.
  - A short frame (LRCK toggles before all bits are sent) truncates the word. The unsent LSBs are discarded.

## Timing
- Reset values:
  - `AUD_DACDAT` = 0, `write_ready` = 1, `fifo_level` = 0, `underflow` = 0.
  - State = `IDLE`, FIFO pointers = 0, shift and holding registers = 0.
- Asserting `reset_n` mid-word:
  - All outputs take their reset values immediately; the FIFO is emptied.
  - After release, the block waits in `IDLE` for an LRCK falling edge. No partial word is ever sent.
- Push latency: a push accepted in cycle N appears in `fifo_level` at N+1. `write_ready` falls at N+1 if that push filled the FIFO.
- Pop latency: `fifo_level` decrements the cycle after the detected LRCK falling edge, and `write_ready` rises in that same cycle.
- Pin-to-data latency: `AUD_DACDAT` updates 3 `CLOCK_50` cycles after the BCLK falling edge at the pin (2 synchroniser cycles + 1 output register).
  - This needs a BCLK half-period of at least 4 `CLOCK_50` cycles, i.e. BCLK ≤ 6.25 MHz.
- `underflow` is high for exactly one cycle per empty frame-start, in the same cycle as the zero load.

## Test plan
- **Reset:** hold `reset_n` = 0 with `write` = 1 and BCLK/LRCK toggling -> `AUD_DACDAT` = 0, `write_ready` = 1, `fifo_level` = 0, `underflow` = 0 throughout.
- **Single pair:** push left = 24'hABCDEF, right = 24'h123456. BCLK period 16 cycles, 32 BCLKs per LRCK half-frame.
  - After the LRCK falling edge: one delay BCLK of 0, then bits 1010_1011_1100_1101_1110_1111, then zeros.
  - After the LRCK rising edge: one 0, then 0001_0010_0011_0100_0101_0110.
- **Full FIFO:** push 4 pairs back-to-back -> `write_ready` = 0 from the cycle after the 4th push; `fifo_level` = 4.
  - A 5th `write` is ignored.
  - The next four frames transmit the pairs in push order.
- **Underflow:** empty FIFO across two frames -> all-zero words and two `underflow` pulses, one per LRCK falling edge.
  - A push mid-frame is transmitted in the following frame.
- **Simultaneous push and pop:** `fifo_level` = 2, `write` asserted in the same cycle as the pop -> `fifo_level` stays 2, and the data order is preserved.
- **Reset mid-frame:** pulse `reset_n` low during bit 10 of a left word -> `AUD_DACDAT` goes to 0 at once.
  - After release, push 24'h800001 and observe nothing until the next LRCK falling edge.
  - The full word is then sent starting with MSB 1.
